// File: rtl/dmem_stall_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage stall controller.
// The master modport is the controller; the slave modport is the pipeline and memory around it.
interface dmem_stall_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            MemtoRegM;
    logic            MemWriteM;
    logic [XLEN-1:0] ALUOutM;
    logic [XLEN-1:0] WriteDataM;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] ReadDataM;
    logic            stall;
    logic            flush_w;
    logic            mem_err;

    modport master (
        input  MemtoRegM, MemWriteM, ALUOutM, WriteDataM, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, ReadDataM, stall, flush_w, mem_err
    );

    modport slave (
        output MemtoRegM, MemWriteM, ALUOutM, WriteDataM, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, ReadDataM, stall, flush_w, mem_err
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: one req/ack per load/store, pipeline frozen meanwhile.
// Optional BUSY watchdog enabled by defining DMEM_TIMEOUT_EN (limit set by TIMEOUT).
module dmem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_stall_ctrl_if.master  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("dmem_stall_ctrl: TIMEOUT must be in 1..255");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_req;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [XLEN-1:0]   w_addr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;
    logic [XLEN-1:0]   w_rdata_nxt;
    logic              w_acc;
    logic              w_stall;

    assign w_acc = bus.MemtoRegM | bus.MemWriteM;

`ifdef DMEM_TIMEOUT_EN
    logic              r_err;
    logic              w_err_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next register values; ack in the same edge as expiry wins
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
`ifdef DMEM_TIMEOUT_EN
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = S_BUSY;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = bus.MemWriteM;
                    w_addr_nxt  = bus.ALUOutM;
                    w_wdata_nxt = bus.WriteDataM;
`ifdef DMEM_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (bus.dmem_ack) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    if (!r_we) begin
                        w_rdata_nxt = bus.dmem_rdata;
                    end
`ifdef DMEM_TIMEOUT_EN
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                    if (!r_we) begin
                        w_rdata_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign bus.mem_err = r_err;
`else
    assign bus.mem_err = 1'b0;
`endif

    // Hold is raised the same cycle an access appears, and never while in reset
    assign w_stall = rst_n & (((r_state == S_IDLE) & w_acc) | (r_state == S_BUSY));

    assign bus.stall      = w_stall;
    assign bus.flush_w    = w_stall;
    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.ReadDataM  = r_rdata;
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: directed vector table, reset/timeout sequences, randomized transactions vs. a timeline model.
module tb_dmem_stall_ctrl;
    localparam int unsigned TO      = 3;
    localparam int unsigned NTXN    = 40;
    localparam int unsigned MAX_LAT = 6;
    localparam int unsigned NVEC    = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_stall_ctrl_if if0 ();
    dmem_stall_ctrl_if if1 ();

    dmem_stall_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    dmem_stall_ctrl #(.TIMEOUT(TO)) u_dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdm;
    } vec_t;

    vec_t        vec [NVEC];
    logic [31:0] mem_m [16];

    // timeline model state: what the controller last latched / captured
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic mr, input logic mw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        if0.MemtoRegM  = mr;
        if0.MemWriteM  = mw;
        if0.ALUOutM    = addr;
        if0.WriteDataM = wdata;
        if0.dmem_ack   = ack;
        if0.dmem_rdata = rdata;
    endtask

    task automatic drive1(input logic mr, input logic [31:0] addr, input logic ack, input logic [31:0] rdata);
        if1.MemtoRegM  = mr;
        if1.MemWriteM  = 1'b0;
        if1.ALUOutM    = addr;
        if1.WriteDataM = 32'h0;
        if1.dmem_ack   = ack;
        if1.dmem_rdata = rdata;
    endtask

    task automatic check0(input string nm, input logic e_stall, input logic e_req, input logic e_we,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rdm);
        chk({nm, ".stall"}, 32'(if0.stall), 32'(e_stall));
        chk({nm, ".flush_w"}, 32'(if0.flush_w), 32'(e_stall));
        chk({nm, ".req"}, 32'(if0.dmem_req), 32'(e_req));
        chk({nm, ".we"}, 32'(if0.dmem_we), 32'(e_we));
        chk({nm, ".addr"}, if0.dmem_addr, e_addr);
        chk({nm, ".wdata"}, if0.dmem_wdata, e_wdata);
        chk({nm, ".rdm"}, if0.ReadDataM, e_rdm);
        chk({nm, ".err"}, 32'(if0.mem_err), 32'h0);
    endtask

    task automatic check1(input string nm, input logic e_stall, input logic e_req,
                          input logic e_err, input logic [31:0] e_rdm);
        chk({nm, ".stall"}, 32'(if1.stall), 32'(e_stall));
        chk({nm, ".req"}, 32'(if1.dmem_req), 32'(e_req));
        chk({nm, ".err"}, 32'(if1.mem_err), 32'(e_err));
        chk({nm, ".rdm"}, if1.ReadDataM, e_rdm);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic mr, input logic mw, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ack, input logic [31:0] rdata, input logic e_stall, input logic e_req,
                                input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [31:0] e_rdm);
        vec_t v;
        v.mr = mr; v.mw = mw; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdm = e_rdm;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors: spurious ack, load with ack in cycle 1, back-to-back store with 4 wait cycles
        vec[0]  = mk(0, 0, 32'h0,  32'h0,         1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,  32'h0,         32'h0);
        vec[1]  = mk(1, 0, 32'h40, 32'h0,         0, 32'h0,         1, 0, 0, 32'h0,  32'h0,         32'h0);
        vec[2]  = mk(1, 0, 32'h40, 32'h0,         1, 32'h1234_5678, 1, 1, 0, 32'h40, 32'h0,         32'h0);
        vec[3]  = mk(1, 0, 32'h40, 32'h0,         0, 32'h0,         0, 0, 0, 32'h40, 32'h0,         32'h1234_5678);
        vec[4]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         1, 0, 0, 32'h40, 32'h0,         32'h1234_5678);
        vec[5]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         1, 1, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[6]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         1, 1, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[7]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         1, 1, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[8]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         1, 1, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[9]  = mk(0, 1, 32'h80, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[10] = mk(0, 1, 32'h80, 32'hCAFE_F00D, 0, 32'h0,         0, 0, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[11] = mk(0, 0, 32'h0,  32'h0,         1, 32'h5555_5555, 0, 0, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);
        vec[12] = mk(0, 0, 32'h0,  32'h0,         0, 32'h0,         0, 0, 1, 32'h80, 32'hCAFE_F00D, 32'h1234_5678);

        // Reset with an access pending on the inputs: stall must stay low
        rst_n = 1'b0;
        drive0(1, 0, 32'h40, 32'h0, 0, 32'h0);
        drive1(0, 32'h0, 0, 32'h0);
        next_cyc();
        next_cyc();
        @(negedge clk);
        check0("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        drive0(0, 0, 32'h0, 32'h0, 0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive0(vec[i].mr, vec[i].mw, vec[i].addr, vec[i].wdata, vec[i].ack, vec[i].rdata);
            @(negedge clk);
            check0($sformatf("vec%0d", i), vec[i].e_stall, vec[i].e_req, vec[i].e_we,
                   vec[i].e_addr, vec[i].e_wdata, vec[i].e_rdm);
            next_cyc();
        end

        // Reset asserted in the second BUSY cycle of a load
        drive0(1, 0, 32'h44, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("rstmid.c0.stall", 32'(if0.stall), 32'h1);
        next_cyc();
        @(negedge clk);
        chk("rstmid.c1.req", 32'(if0.dmem_req), 32'h1);
        chk("rstmid.c1.addr", if0.dmem_addr, 32'h44);
        next_cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.async.req", 32'(if0.dmem_req), 32'h0);
        chk("rstmid.async.stall", 32'(if0.stall), 32'h0);
        chk("rstmid.async.addr", if0.dmem_addr, 32'h0);
        next_cyc();
        drive0(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check0("rstmid.after", 0, 0, 0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        drive0(1, 0, 32'h48, 32'h0, 0, 32'h0);
        @(negedge clk);
        check0("rstld.c0", 1, 0, 0, 32'h0, 32'h0, 32'h0);
        next_cyc();
        drive0(1, 0, 32'h48, 32'h0, 1, 32'hA5A5_A5A5);
        @(negedge clk);
        check0("rstld.c1", 1, 1, 0, 32'h48, 32'h0, 32'h0);
        next_cyc();
        drive0(1, 0, 32'h48, 32'h0, 0, 32'h0);
        @(negedge clk);
        check0("rstld.c2", 0, 0, 0, 32'h48, 32'h0, 32'hA5A5_A5A5);
        next_cyc();
        drive0(0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Second instance: a normal load first so ReadDataM is non-zero
        drive1(1, 32'h10, 0, 32'h0);
        next_cyc();
        drive1(1, 32'h10, 1, 32'h77);
        next_cyc();
        drive1(1, 32'h10, 0, 32'h0);
        @(negedge clk);
        check1("to.pre", 0, 0, 0, 32'h77);
        next_cyc();
        drive1(0, 32'h0, 0, 32'h0);
        next_cyc();

        // Load that never gets an ack
        drive1(1, 32'h100, 0, 32'h0);
        @(negedge clk);
        check1("to.c0", 1, 0, 0, 32'h77);
        next_cyc();
`ifdef DMEM_TIMEOUT_EN
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            check1($sformatf("to.busy%0d", k), 1, 1, 0, 32'h77);
            next_cyc();
        end
        @(negedge clk);
        check1("to.done", 0, 0, 1, 32'h0);
        next_cyc();
        drive1(0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1($sformatf("to.idle%0d", k), 0, 0, 1, 32'h0);
            next_cyc();
        end
        drive1(1, 32'h104, 0, 32'h0);
        next_cyc();
        drive1(1, 32'h104, 1, 32'h99);
        next_cyc();
        drive1(1, 32'h104, 0, 32'h0);
        @(negedge clk);
        check1("to.resume", 0, 0, 1, 32'h99);
        next_cyc();
`else
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) drive1(1, 32'h100, 1, 32'h99);
            @(negedge clk);
            check1($sformatf("noto.busy%0d", k), 1, 1, 0, 32'h77);
            next_cyc();
        end
        drive1(1, 32'h100, 0, 32'h0);
        @(negedge clk);
        check1("noto.done", 0, 0, 0, 32'h99);
        next_cyc();
`endif
        drive1(0, 32'h0, 0, 32'h0);

        // Randomized transactions against a timeline model
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
        m_we    = 1'b0;
        m_addr  = 32'h48;
        m_wdata = 32'h0;
        m_rdm   = 32'hA5A5_A5A5;
        for (int t = 0; t < int'(NTXN); t++) begin
            int          gap;
            int          lat;
            int          idx;
            logic        is_st;
            logic        both;
            logic [31:0] a;
            logic [31:0] wd;
            gap   = int'($urandom_range(2, 0));
            lat   = int'($urandom_range(MAX_LAT, 1));
            idx   = int'($urandom_range(15, 0));
            is_st = 1'($urandom);
            both  = is_st && ($urandom_range(3, 0) == 0);
            a     = 32'h1000 + 32'(idx * 4);
            wd    = $urandom;
            for (int g = 0; g < gap; g++) begin
                drive0(0, 0, $urandom, $urandom, 1'($urandom), $urandom);
                @(negedge clk);
                check0($sformatf("rnd%0d.gap%0d", t, g), 0, 0, m_we, m_addr, m_wdata, m_rdm);
                next_cyc();
            end
            for (int k = 0; k <= lat + 1; k++) begin
                logic        ack;
                logic [31:0] rd;
                if (k == lat) begin
                    ack = 1'b1;
                    rd  = is_st ? $urandom : mem_m[idx];
                end else begin
                    ack = (k == 0 || k == lat + 1) ? 1'($urandom) : 1'b0;
                    rd  = $urandom;
                end
                drive0(both | ~is_st, is_st, a, wd, ack, rd);
                if (k == 1) begin
                    m_we    = is_st;
                    m_addr  = a;
                    m_wdata = wd;
                end
                if (k == lat + 1 && !is_st) m_rdm = mem_m[idx];
                @(negedge clk);
                check0($sformatf("rnd%0d.k%0d", t, k), (k <= lat), (k >= 1 && k <= lat),
                       m_we, m_addr, m_wdata, m_rdm);
                next_cyc();
            end
            if (is_st) mem_m[idx] = wd;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
